// File: rtl/config_bus_sequencer.sv
// Config bus sequencer: queues network read/write requests in a small FIFO
// and replays them onto the core config port one access at a time, returning
// captured readback data over a valid/ready response channel.
module config_bus_sequencer #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]      req_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic [ADDR_WIDTH-1:0]      config_config_addr,
  output logic [DATA_WIDTH-1:0]      config_config_data,
  output logic                       config_read,
  output logic                       config_write,
  input  logic [DATA_WIDTH-1:0]      read_config_data,
  output logic [$clog2(DEPTH)+1:0]   pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  req_t            mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            alive;
  logic            full, empty, push, pop;
  req_t            head;

  state_t          state, state_d;
  logic            cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic [2:0]      cnt;

  // req_ready stays low while reset is held and comes up on the first clock after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = alive && !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;
  assign head      = mem[rptr];

  // FIFO storage; no reset needed, occupancy tracks validity
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{write: req_write, addr: req_addr, data: req_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state;
    config_read  = 1'b0;
    config_write = 1'b0;
    resp_valid   = 1'b0;
    case (state)
      IDLE:  if (!empty) state_d = ISSUE;
      ISSUE: begin
        config_write = cmd_write;
        config_read  = !cmd_write;
        if (cmd_write)              state_d = IDLE;
        else if (READ_LATENCY == 0) state_d = RESP;
        else                        state_d = WAIT;
      end
      WAIT:  if (cnt == 3'd1) state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, latency counter and readback capture.
  // Bus data only changes on writes so reads leave the last written value on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      data_q    <= '0;
      resp_q    <= '0;
      cnt       <= '0;
    end else begin
      if (pop) begin
        cmd_write <= head.write;
        cmd_addr  <= head.addr;
        if (head.write) data_q <= head.data;
      end
      if (state == ISSUE && !cmd_write) begin
        if (READ_LATENCY == 0) resp_q <= read_config_data;
        else                   cnt    <= 3'(READ_LATENCY);
      end
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == 3'd1) resp_q <= read_config_data;
      end
    end
  end

  assign config_config_addr = cmd_addr;
  assign config_config_data = data_q;
  assign resp_data          = resp_q;
  assign pending            = {1'b0, count} + {{CW{1'b0}}, (state != IDLE)};

endmodule

// File: tb/tb_config_bus_sequencer.sv
// Directed bench for config_bus_sequencer: one instance with zero read
// latency (core model answers combinationally from the address) and one
// with READ_LATENCY=2 whose readback is driven cycle by cycle.
module tb_config_bus_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: READ_LATENCY = 0
  logic        a_valid = 0, a_write = 0, a_resp_ready = 0;
  logic [7:0]  a_addr = 0;
  logic [31:0] a_data = 0;
  logic        a_ready, a_resp_valid, a_cread, a_cwrite;
  logic [31:0] a_resp_data, a_cdata, a_rd;
  logic [7:0]  a_caddr;
  logic [3:0]  a_pending;

  // instance B: READ_LATENCY = 2
  logic        b_valid = 0, b_write = 0, b_resp_ready = 0;
  logic [7:0]  b_addr = 0;
  logic [31:0] b_data = 0, b_rd = 0;
  logic        b_ready, b_resp_valid, b_cread, b_cwrite;
  logic [31:0] b_resp_data, b_cdata;
  logic [7:0]  b_caddr;
  logic [3:0]  b_pending;

  assign a_rd = (a_caddr == 8'h00) ? 32'h12345678 : {24'hC0FFEE, a_caddr};

  config_bus_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4), .READ_LATENCY(0)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_data(a_data),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data),
    .config_config_addr(a_caddr), .config_config_data(a_cdata),
    .config_read(a_cread), .config_write(a_cwrite),
    .read_config_data(a_rd), .pending(a_pending));

  config_bus_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4), .READ_LATENCY(2)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_data(b_data),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
    .config_config_addr(b_caddr), .config_config_data(b_cdata),
    .config_read(b_cread), .config_write(b_cwrite),
    .read_config_data(b_rd), .pending(b_pending));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({a_ready, a_resp_valid, a_cread, a_cwrite, a_caddr, a_cdata, a_resp_data, a_pending} !== '0) begin
      errors++; $display("FAIL reset_outs_a: ready=%b rv=%b rd=%b wr=%b addr=%h pend=%0d, want all 0",
                         a_ready, a_resp_valid, a_cread, a_cwrite, a_caddr, a_pending);
    end
    checks++;
    if ({b_ready, b_resp_valid, b_cread, b_cwrite, b_caddr, b_cdata, b_resp_data, b_pending} !== '0) begin
      errors++; $display("FAIL reset_outs_b: ready=%b rv=%b pend=%0d, want all 0", b_ready, b_resp_valid, b_pending);
    end
    @(posedge clk); #1; reset = 1'b1;
    tick();
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got a=%b b=%b want 1", a_ready, b_ready);
    end
  endtask

  task automatic test_single_write();
    int wr_cnt = 0, wr_idx = -1, rv_cnt = 0;
    logic [7:0]  wa = 0;
    logic [31:0] wd = 0;
    logic [3:0]  pend2 = 0;
    a_valid = 1; a_write = 1; a_addr = 8'h01; a_data = 32'hDEADBEEF;
    tick();
    a_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      if (a_cwrite) begin wr_cnt++; wr_idx = i; wa = a_caddr; wd = a_cdata; end
      if (a_resp_valid) rv_cnt++;
      if (i == 2) pend2 = a_pending;
      tick();
    end
    checks++;
    if (wr_cnt != 1 || wr_idx != 2) begin
      errors++; $display("FAIL write_strobe: count=%0d at=%0d, want count=1 at=2", wr_cnt, wr_idx);
    end
    checks++;
    if (wa !== 8'h01 || wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_bus: addr=%h data=%h, want 01 deadbeef", wa, wd);
    end
    checks++;
    if (rv_cnt != 0) begin errors++; $display("FAIL write_no_resp: resp_valid cycles=%0d want 0", rv_cnt); end
    checks++;
    if (pend2 !== 4'd1) begin errors++; $display("FAIL write_pending_issue: got %0d want 1", pend2); end
    checks++;
    if (a_caddr !== 8'h01 || a_cdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_bus_hold: addr=%h data=%h, want 01 deadbeef", a_caddr, a_cdata);
    end
  endtask

  task automatic test_read_lat0();
    int rd_cnt = 0, rd_idx = -1, rv_idx = -1;
    logic [31:0] got = 0;
    a_resp_ready = 0;
    a_valid = 1; a_write = 0; a_addr = 8'h00;
    tick();
    a_valid = 0;
    for (int i = 1; i <= 6; i++) begin
      if (a_cread) begin rd_cnt++; rd_idx = i; end
      if (a_resp_valid && rv_idx < 0) begin rv_idx = i; got = a_resp_data; end
      tick();
    end
    checks++;
    if (rd_cnt != 1 || rd_idx != 2) begin
      errors++; $display("FAIL lat0_read_strobe: count=%0d at=%0d, want 1 at 2", rd_cnt, rd_idx);
    end
    checks++;
    if (rv_idx != 3 || got !== 32'h12345678) begin
      errors++; $display("FAIL lat0_resp: first at=%0d data=%h, want at 3 data 12345678", rv_idx, got);
    end
    checks++;
    if (a_cwrite !== 1'b0 || a_cdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat0_data_hold: wr=%b data=%h, want 0 deadbeef", a_cwrite, a_cdata);
    end
    a_resp_ready = 1;
    tick();
    checks++;
    if (a_resp_valid !== 1'b0 || a_pending !== 4'd0) begin
      errors++; $display("FAIL lat0_handshake: rv=%b pend=%0d, want 0 0", a_resp_valid, a_pending);
    end
  endtask

  task automatic test_read_lat2();
    int rd_cnt = 0, rd_idx = -1, rv_idx = -1, addr_bad = 0;
    logic [31:0] got = 0;
    b_resp_ready = 0;
    b_valid = 1; b_write = 0; b_addr = 8'h05;
    tick();
    b_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      if (b_cread) begin rd_cnt++; rd_idx = i; end
      if (i >= 2 && i <= 4 && b_caddr !== 8'h05) addr_bad++;
      if (b_resp_valid && rv_idx < 0) begin rv_idx = i; got = b_resp_data; end
      b_rd = 32'h1000_0000 + 32'(i);
      tick();
    end
    checks++;
    if (rd_cnt != 1 || rd_idx != 2) begin
      errors++; $display("FAIL lat2_read_strobe: count=%0d at=%0d, want 1 at 2", rd_cnt, rd_idx);
    end
    checks++;
    if (addr_bad != 0) begin errors++; $display("FAIL lat2_addr_stable: bad cycles=%0d want 0", addr_bad); end
    checks++;
    if (rv_idx != 5 || got !== 32'h1000_0004) begin
      errors++; $display("FAIL lat2_capture: first at=%0d data=%h, want at 5 data 10000004", rv_idx, got);
    end
    checks++;
    if (b_resp_data !== 32'h1000_0004) begin
      errors++; $display("FAIL lat2_resp_hold: got %h want 10000004", b_resp_data);
    end
    b_resp_ready = 1;
    tick();
    b_resp_ready = 0;
  endtask

  task automatic test_fifo_full();
    int acc = 0, nacc = 0, got = 0, order_bad = 0;
    logic [31:0] exp;
    a_resp_ready = 0;
    a_write = 0;
    for (int c = 0; c < 8; c++) begin
      a_valid = (acc < 6);
      a_addr  = 8'h10 + 8'(acc);
      nacc = (a_valid && a_ready) ? acc + 1 : acc;
      tick();
      acc = nacc;
    end
    a_valid = 0;
    checks++;
    if (acc != 5) begin errors++; $display("FAIL full_accepts: got %0d want 5", acc); end
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", a_ready); end
    checks++;
    if (a_pending !== 4'd5) begin errors++; $display("FAIL full_pending: got %0d want 5", a_pending); end
    a_resp_ready = 1;
    for (int c = 0; c < 30; c++) begin
      if (a_resp_valid) begin
        exp = {24'hC0FFEE, 8'h10 + 8'(got)};
        if (a_resp_data !== exp) begin
          order_bad++;
          $display("FAIL full_drain_data[%0d]: got %h want %h", got, a_resp_data, exp);
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 5 || order_bad != 0) begin
      errors++; $display("FAIL full_drain: responses=%0d bad=%0d, want 5 and 0", got, order_bad);
    end
    checks++;
    if (a_pending !== 4'd0 || a_ready !== 1'b1) begin
      errors++; $display("FAIL full_empty_after: pend=%0d ready=%b, want 0 1", a_pending, a_ready);
    end
  endtask

  task automatic test_backpressure();
    int n = 0, strobes = 0, unstable = 0, wr_idx = -1;
    logic [7:0]  wa = 0;
    logic [31:0] wd = 0;
    a_resp_ready = 0;
    a_valid = 1; a_write = 0; a_addr = 8'h20;
    tick();
    a_write = 1; a_addr = 8'h21; a_data = 32'hCAFEF00D;
    tick();
    a_valid = 0;
    while (!a_resp_valid && n < 10) begin tick(); n++; end
    checks++;
    if (!a_resp_valid) begin errors++; $display("FAIL bp_resp_timeout: resp_valid=%b want 1", a_resp_valid); end
    for (int c = 0; c < 10; c++) begin
      if (a_cread || a_cwrite) strobes++;
      if (a_resp_data !== 32'hC0FFEE20 || !a_resp_valid) unstable++;
      tick();
    end
    checks++;
    if (strobes != 0 || unstable != 0) begin
      errors++; $display("FAIL bp_stall: strobes=%0d unstable=%0d, want 0 0", strobes, unstable);
    end
    a_resp_ready = 1;
    tick();
    a_resp_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      if (a_cwrite && wr_idx < 0) begin wr_idx = i; wa = a_caddr; wd = a_cdata; end
      tick();
    end
    checks++;
    if (wr_idx != 2 || wa !== 8'h21 || wd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL bp_write_after: at=%0d addr=%h data=%h, want at 2 21 cafef00d", wr_idx, wa, wd);
    end
  endtask

  task automatic test_reset_in_wait();
    int junk = 0, wr_idx = -1;
    logic [7:0]  wa = 0;
    logic [31:0] wd = 0;
    logic saw_read = 0;
    b_resp_ready = 0;
    b_valid = 1; b_write = 0; b_addr = 8'h33;
    tick();
    b_write = 1; b_addr = 8'h44; b_data = 32'h0000_0077;
    tick();
    b_valid = 0;
    saw_read = b_cread;
    tick();
    checks++;
    if (!saw_read || b_caddr !== 8'h33 || b_pending !== 4'd2) begin
      errors++; $display("FAIL rst_pre_wait: read=%b addr=%h pend=%0d, want 1 33 2", saw_read, b_caddr, b_pending);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({b_ready, b_resp_valid, b_cread, b_cwrite, b_caddr, b_cdata, b_resp_data, b_pending} !== '0) begin
      errors++; $display("FAIL rst_async_outs: addr=%h rv=%b pend=%0d ready=%b, want all 0",
                         b_caddr, b_resp_valid, b_pending, b_ready);
    end
    @(posedge clk); #1; reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (b_cread || b_cwrite || b_resp_valid) junk++;
      tick();
    end
    checks++;
    if (junk != 0) begin errors++; $display("FAIL rst_stale: activity cycles=%0d want 0", junk); end
    b_valid = 1; b_write = 1; b_addr = 8'h01; b_data = 32'h5555AAAA;
    tick();
    b_valid = 0;
    for (int i = 1; i <= 6; i++) begin
      if (b_cwrite && wr_idx < 0) begin wr_idx = i; wa = b_caddr; wd = b_cdata; end
      if (b_resp_valid) junk++;
      tick();
    end
    checks++;
    if (wr_idx != 2 || wa !== 8'h01 || wd !== 32'h5555AAAA || junk != 0) begin
      errors++; $display("FAIL rst_new_write: at=%0d addr=%h data=%h resp=%0d, want at 2 01 5555aaaa 0",
                         wr_idx, wa, wd, junk);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_lat0();
    test_read_lat2();
    test_fifo_full();
    test_backpressure();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_bus_sequencer.md
Name: config_bus_sequencer

Overview:
- Sits directly upstream of a tile core's configuration port and drives config_config_addr/config_config_data/config_read/config_write.
- Accepts queued read/write requests from the global configuration network over a valid/ready interface and issues them one at a time.
- Captures the core's read_config_data for reads and returns it over a valid/ready response channel.
- Converts bursty network traffic into the single-outstanding-access protocol that the core's config registers and readback mux expect.

Parameters:
- ADDR_WIDTH, 8, config address width; matches core config_config_addr.
- DATA_WIDTH, 32, config data width; matches config_config_data and read_config_data.
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- READ_LATENCY, 0, cycles from the read-issue cycle to the capture of read_config_data; range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  target config address.
- req_data  in  DATA_WIDTH  write data; ignored for reads.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  DATA_WIDTH  captured read data.
- config_config_addr  out  ADDR_WIDTH  to core.
- config_config_data  out  DATA_WIDTH  to core.
- config_read  out  1  to core; read strobe.
- config_write  out  1  to core; write strobe.
- read_config_data  in  DATA_WIDTH  from core; combinational readback.
- pending  out  clog2(DEPTH)+2  FIFO occupancy plus 1 when the FSM is not IDLE.

Behaviour:
Reset (reset low, asynchronous assert, synchronous release at clk):
- FIFO empty, FSM in IDLE.
- All outputs 0, except req_ready = 1 once reset is released.

Request FIFO:
- Push on req_valid && req_ready.
- req_ready = !full. It is driven low whenever the FIFO is full, even if a pop happens in the same cycle (no bypass).
- Simultaneous push and pop when not full: occupancy is unchanged.
- A pushed entry is visible to the FSM on the next cycle. Pointers wrap modulo DEPTH.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head into the command registers and go to ISSUE. Otherwise stay.
- ISSUE (exactly one cycle):
  - config_config_addr = cmd addr.
  - Write: config_config_data = cmd data, config_write = 1. Next state IDLE.
  - Read: config_read = 1. If READ_LATENCY == 0, capture read_config_data into resp_data at the end of this cycle and go to RESP. Otherwise load the counter with READ_LATENCY and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, capture read_config_data at the end of that cycle and go to RESP.
  - Capture therefore occurs exactly READ_LATENCY cycles after the ISSUE cycle.
  - config_config_addr is held stable through capture.
- RESP: resp_valid = 1 and resp_data is stable until resp_ready is high. The handshake cycle goes to IDLE.
  - No new request is issued while in RESP; at most one access is outstanding.

Strobes and bus outputs:
- config_read and config_write are high only in ISSUE, never both, and each for exactly one cycle per request.
- config_config_addr and config_config_data hold their last issued values outside ISSUE; they are not returned to 0.

Throughput:
- Write: 2 cycles per request (IDLE + ISSUE).
- Read: 3 + READ_LATENCY cycles minimum, plus any resp_ready stall.

Writes produce no response.

pending is updated combinationally from the registered FIFO count and FSM state.

Reset mid-operation: the in-flight read is discarded, the FIFO contents are lost, and the strobes drop immediately.

Test Plan:
1. Single write (req_write=1, req_addr=8'h01, req_data=32'hDEADBEEF):
   - config_write is high for exactly one cycle, 2 cycles after acceptance, with addr 8'h01 and data 32'hDEADBEEF.
   - resp_valid never asserts.
2. Read with READ_LATENCY=0, core model returning 32'h12345678 for addr 8'h00:
   - config_read is high for one cycle.
   - resp_valid rises on the next cycle with resp_data=32'h12345678.
3. Read with READ_LATENCY=2:
   - The value present on read_config_data 2 cycles after the config_read cycle is captured.
   - Changing read_config_data on cycles 1 and 3 does not affect resp_data.
4. FIFO full, DEPTH=4, resp_ready held low:
   - Push 6 back-to-back reads: req_ready drops after 5 acceptances (4 queued + 1 in flight).
   - pending reads 5.
   - Raising resp_ready drains all 5 responses in order.
5. Backpressure: hold resp_ready=0 for 10 cycles during RESP.
   - resp_data is stable throughout, no config strobes occur, and the queued write issues only after the handshake.
6. Reset asserted while in WAIT:
   - All outputs go to 0 asynchronously and pending reads 0.
   - After release, a new write to 8'h01 issues normally, with no stale response.
